// File: rtl/pack_stream_pkg.sv
// pack_stream_pkg
// Shared definitions for the pixel-to-word packer.
//   state_e      : packer control states (RUN accepts pixels, FLUSH drains the
//                  residual left behind by a final pixel that straddled a word)
//   byte_lane_en : byte-count-to-mask function, evaluated one byte lane at a
//                  time so it works for any output word width
package pack_stream_pkg;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_e;

    // Lane 'lane' of a byte mask is enabled when that whole byte lies below
    // validBits. All widths in this design are byte multiples, so partial
    // bytes never occur.
    function automatic logic byte_lane_en(input int unsigned validBits,
                                          input int unsigned lane);
        return (lane * 32'd8) < validBits;
    endfunction

endpackage

// File: rtl/pack_stream_if.sv
// pack_stream_if
// Streaming bus between a pixel producer / word consumer and pack_stream.
//   master : drives pixels (iwr_en, idata, ialign, ilast) and oready,
//            receives iready and the packed word signals
//   slave  : pack_stream side; receives pixels and oready, drives iready,
//            owr_en, odata, omask, olast_en and odrop
interface pack_stream_if
    import pack_stream_pkg::*;
#(
    parameter int ISIZE = 24,
    parameter int OSIZE = 256
);

    logic               iwr_en;
    logic               iready;
    logic [ISIZE-1:0]   idata;
    logic               ialign;
    logic               ilast;
    logic               owr_en;
    logic               oready;
    logic [OSIZE-1:0]   odata;
    logic [OSIZE/8-1:0] omask;
    logic               olast_en;
    logic               odrop;

    modport master (
        output iwr_en, idata, ialign, ilast, oready,
        input  iready, owr_en, odata, omask, olast_en, odrop
    );

    modport slave (
        input  iwr_en, idata, ialign, ilast, oready,
        output iready, owr_en, odata, omask, olast_en, odrop
    );

endinterface

// File: rtl/pack_stream_byte_mask_gen.sv
// byte_mask_gen
// Turns a count of valid bits (always a byte multiple) into a byte-enable mask
// with the low count/8 lanes set.
//   bits_i : number of valid bits in the word
//   mask_o : byte enables, bit n covers byte n of the word
module byte_mask_gen
    import pack_stream_pkg::*;
#(
    parameter int NBYTES = 32,
    parameter int BITS_W = 9
) (
    input  logic [BITS_W-1:0] bits_i,
    output logic [NBYTES-1:0] mask_o
);

    // Each lane is decided independently against the shared count.
    always_comb begin
        mask_o = '0;
        for (int unsigned n = 0; n < NBYTES; n++) begin
            mask_o[n] = byte_lane_en(32'(bits_i), n);
        end
    end

endmodule

// File: rtl/pack_stream.sv
// pack_stream
// Packs ISIZE-bit pixels little-endian into OSIZE-bit words with byte enables.
//   clock : sole clock, rising edge
//   rst   : asynchronous active-high reset
//   bus   : pack_stream_if slave modport
//           iwr_en/iready/idata/ialign/ilast : pixel input handshake
//           owr_en/oready/odata/omask        : packed word output handshake
//           olast_en                         : final word of a burst
//           odrop                            : partial word discarded by ialign
module pack_stream
    import pack_stream_pkg::*;
#(
    parameter int ISIZE = 24,
    parameter int OSIZE = 256
) (
    input  logic         clock,
    input  logic         rst,
    pack_stream_if.slave bus
);

    localparam int ACC_W  = OSIZE + ISIZE;
    localparam int FILL_W = $clog2(ACC_W + 1);
    localparam int NBYTES = OSIZE / 8;

    localparam logic [FILL_W-1:0] OSIZE_F = FILL_W'(OSIZE);
    localparam logic [FILL_W-1:0] ISIZE_F = FILL_W'(ISIZE);

    state_e              state_q, state_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [FILL_W-1:0]   fill_q, fill_d;
    logic [OSIZE-1:0]    odata_q, odata_d;
    logic [NBYTES-1:0]   omask_q, omask_d;
    logic                owr_en_q, owr_en_d;
    logic                olast_q, olast_d;
    logic                odrop_q, odrop_d;

    logic [ACC_W-1:0]    baseAcc, newAcc;
    logic [FILL_W-1:0]   baseFill, newFill, emitBits;
    logic [NBYTES-1:0]   emitMask;
    logic                emit;
    logic                outFree;
    logic                accept;

    // The output register can take a new word when it is empty or its
    // current word leaves this cycle; pixels are only taken in RUN.
    assign outFree    = ~owr_en_q | bus.oready;
    assign bus.iready = outFree & (state_q == RUN);
    assign accept     = bus.iwr_en & bus.iready;

    assign bus.owr_en   = owr_en_q;
    assign bus.odata    = odata_q;
    assign bus.omask    = omask_q;
    assign bus.olast_en = olast_q;
    assign bus.odrop    = odrop_q;

    byte_mask_gen #(
        .NBYTES (NBYTES),
        .BITS_W (FILL_W)
    ) u_mask (
        .bits_i (emitBits),
        .mask_o (emitMask)
    );

    // Next-state logic for the accumulator, fill count, control state and
    // the registered output word. Bits of the accumulator above fill are
    // kept at zero at all times, so a partial word needs no extra masking.
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        fill_d   = fill_q;
        odata_d  = odata_q;
        omask_d  = omask_q;
        owr_en_d = owr_en_q & ~bus.oready;
        olast_d  = olast_q;
        odrop_d  = 1'b0;
        emit     = 1'b0;
        emitBits = OSIZE_F;

        // ialign restarts the line before the same-cycle pixel is placed.
        baseAcc  = acc_q;
        baseFill = fill_q;
        if (state_q == RUN && bus.ialign) begin
            baseAcc  = '0;
            baseFill = '0;
            acc_d    = '0;
            fill_d   = '0;
            odrop_d  = (fill_q != '0);
        end

        newAcc  = baseAcc | (ACC_W'(bus.idata) << baseFill);
        newFill = baseFill + ISIZE_F;

        if (state_q == RUN) begin
            if (accept) begin
                if (bus.ilast && newFill <= OSIZE_F) begin
                    // Whole burst tail fits in one word.
                    emit     = 1'b1;
                    emitBits = newFill;
                    odata_d  = newAcc[OSIZE-1:0];
                    olast_d  = 1'b1;
                    acc_d    = '0;
                    fill_d   = '0;
                end else if (newFill >= OSIZE_F) begin
                    // Full word out; the remainder slides down to bit 0.
                    // A final pixel that overflowed leaves a residual that
                    // FLUSH sends as the closing word.
                    emit     = 1'b1;
                    emitBits = OSIZE_F;
                    odata_d  = newAcc[OSIZE-1:0];
                    olast_d  = 1'b0;
                    acc_d    = newAcc >> OSIZE;
                    fill_d   = newFill - OSIZE_F;
                    if (bus.ilast) begin
                        state_d = FLUSH;
                    end
                end else begin
                    acc_d  = newAcc;
                    fill_d = newFill;
                end
            end
        end else begin
            if (outFree) begin
                emit     = 1'b1;
                emitBits = fill_q;
                odata_d  = acc_q[OSIZE-1:0];
                olast_d  = 1'b1;
                acc_d    = '0;
                fill_d   = '0;
                state_d  = RUN;
            end
        end

        if (emit) begin
            owr_en_d = 1'b1;
            omask_d  = emitMask;
        end
    end

    // Single register stage for all state and outputs; reset discards any
    // residual so nothing is emitted until new pixels arrive.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state_q  <= RUN;
            acc_q    <= '0;
            fill_q   <= '0;
            odata_q  <= '0;
            omask_q  <= '0;
            owr_en_q <= 1'b0;
            olast_q  <= 1'b0;
            odrop_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            fill_q   <= fill_d;
            odata_q  <= odata_d;
            omask_q  <= omask_d;
            owr_en_q <= owr_en_d;
            olast_q  <= olast_d;
            odrop_q  <= odrop_d;
        end
    end

endmodule

// File: tb/tb_pack_stream.sv
// tb_pack_stream
// Self-checking bench for pack_stream (ISIZE=24, OSIZE=256). A byte-queue
// reference model predicts every emitted word and every odrop pulse.
module tb_pack_stream;

    localparam int ISIZE = 24;
    localparam int OSIZE = 256;
    localparam int NB    = OSIZE / 8;
    localparam int PB    = ISIZE / 8;

    typedef struct packed {
        logic [OSIZE-1:0] data;
        logic [NB-1:0]    mask;
        logic             last;
    } word_t;

    logic clock;
    logic rst;

    pack_stream_if #(.ISIZE(ISIZE), .OSIZE(OSIZE)) bus ();

    pack_stream #(.ISIZE(ISIZE), .OSIZE(OSIZE)) dut (
        .clock (clock),
        .rst   (rst),
        .bus   (bus)
    );

    int         compared   = 0;
    int         mismatched = 0;
    word_t      expQ[$];
    word_t      gotQ[$];
    logic [7:0] resid[$];
    int         expDrops;
    int         gotDrops;
    bit         randReady  = 0;
    word_t      monWord;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Monitor: record every word handed over and every cycle odrop is high.
    always @(negedge clock) begin
        if (!rst) begin
            if (bus.owr_en && bus.oready) begin
                monWord.data = bus.odata;
                monWord.mask = bus.omask;
                monWord.last = bus.olast_en;
                gotQ.push_back(monWord);
            end
            if (bus.odrop) gotDrops++;
        end
    end

    // Random downstream back-pressure when enabled.
    always @(posedge clock) begin
        if (randReady) begin
            #1;
            bus.oready = ($urandom_range(0, 3) != 0);
        end
    end

    // Reference model: the stream is a queue of bytes; a word is simply the
    // next 32 bytes, and a burst tail is whatever bytes are left.
    function automatic void popWord(int n, bit last);
        word_t w;
        w = '0;
        for (int i = 0; i < n; i++) begin
            w.data[8*i +: 8] = resid.pop_front();
            w.mask[i]        = 1'b1;
        end
        w.last = last;
        expQ.push_back(w);
    endfunction

    function automatic void modelAccept(logic [ISIZE-1:0] d, bit align, bit last);
        if (align) begin
            if (resid.size() != 0) expDrops++;
            resid.delete();
        end
        for (int b = 0; b < PB; b++) resid.push_back(d[8*b +: 8]);
        if (last) begin
            while (resid.size() > NB) popWord(NB, 1'b0);
            popWord(resid.size(), 1'b1);
        end else begin
            while (resid.size() >= NB) popWord(NB, 1'b0);
        end
    endfunction

    // Offer one pixel and hold it until accepted (bounded).
    task automatic applyStimulus(input logic [ISIZE-1:0] d, input bit align, input bit last);
        int waited;
        waited     = 0;
        bus.iwr_en = 1'b1;
        bus.idata  = d;
        bus.ialign = align;
        bus.ilast  = last;
        @(negedge clock);
        while (!bus.iready && waited < 100) begin
            waited++;
            @(negedge clock);
        end
        if (!bus.iready) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL accept_timeout: iready=%0b after %0d cycles, required 1", bus.iready, waited);
        end else begin
            modelAccept(d, align, last);
        end
        @(posedge clock);
        #1;
        bus.iwr_en = 1'b0;
        bus.ialign = 1'b0;
        bus.ilast  = 1'b0;
        bus.idata  = '0;
    endtask

    task automatic startScenario();
        gotQ.delete();
        expQ.delete();
        resid.delete();
        expDrops = 0;
        gotDrops = 0;
    endtask

    task automatic drain(output bit timedOut);
        int waited;
        waited    = 0;
        randReady = 0;
        @(posedge clock);
        #2;
        bus.oready = 1'b1;
        while (gotQ.size() < expQ.size() && waited < 300) begin
            @(posedge clock);
            waited++;
        end
        repeat (6) @(posedge clock);
        #1;
        timedOut = (gotQ.size() < expQ.size());
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        bus.iwr_en = 1'b0;
        bus.idata  = '0;
        bus.ialign = 1'b0;
        bus.ilast  = 1'b0;
        bus.oready = 1'b1;
        repeat (2) @(negedge clock);
        compared++; if (bus.owr_en !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_owr_en: got %b want 0", bus.owr_en); end
        compared++; if (bus.olast_en !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_olast_en: got %b want 0", bus.olast_en); end
        compared++; if (bus.odrop !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_odrop: got %b want 0", bus.odrop); end
        compared++; if (bus.odata !== '0) begin mismatched++; $display("[TB] FAIL reset_odata: got %h want 0", bus.odata); end
        compared++; if (bus.omask !== '0) begin mismatched++; $display("[TB] FAIL reset_omask: got %h want 0", bus.omask); end
        compared++; if (bus.iready !== 1'b1) begin mismatched++; $display("[TB] FAIL reset_iready: got %b want 1", bus.iready); end
        @(posedge clock);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_single_word();
        bit to;
        startScenario();
        for (int i = 0; i < 10; i++) applyStimulus(ISIZE'($urandom), 1'b0, 1'b0);
        @(negedge clock);
        compared++; if (bus.owr_en !== 1'b0) begin mismatched++; $display("[TB] FAIL early_word: owr_en got %b want 0", bus.owr_en); end
        @(posedge clock); #1;
        applyStimulus(ISIZE'($urandom), 1'b0, 1'b0);
        @(negedge clock);
        compared++; if (bus.owr_en !== 1'b1) begin mismatched++; $display("[TB] FAIL latency_owr_en: got %b want 1", bus.owr_en); end
        compared++; if (bus.omask !== 32'hFFFF_FFFF) begin mismatched++; $display("[TB] FAIL word11_mask: got %h want ffffffff", bus.omask); end
        compared++; if (bus.olast_en !== 1'b0) begin mismatched++; $display("[TB] FAIL word11_last: got %b want 0", bus.olast_en); end
        compared++; if (expQ.size() < 1 || bus.odata !== expQ[0].data) begin mismatched++; $display("[TB] FAIL word11_data: got %h", bus.odata); end
        @(posedge clock); #1;
        // The 8-bit residual shows up under the next pixel in the final word.
        applyStimulus(ISIZE'($urandom), 1'b0, 1'b1);
        drain(to);
        compared++; if (to || gotQ.size() != 2) begin mismatched++; $display("[TB] FAIL residual_count: got %0d words want 2", gotQ.size()); end
        if (gotQ.size() == 2 && expQ.size() == 2) begin
            compared++; if (gotQ[1].mask !== 32'h0000_000F) begin mismatched++; $display("[TB] FAIL residual_mask: got %h want 0000000f", gotQ[1].mask); end
            compared++; if (gotQ[1] !== expQ[1]) begin mismatched++; $display("[TB] FAIL residual_word: got %h/%b want %h/%b", gotQ[1].data, gotQ[1].last, expQ[1].data, expQ[1].last); end
        end
    endtask

    task automatic test_burst32();
        bit to;
        startScenario();
        for (int i = 0; i < 32; i++) applyStimulus(ISIZE'($urandom), 1'b0, i == 31);
        drain(to);
        compared++; if (to || gotQ.size() != 3) begin mismatched++; $display("[TB] FAIL burst32_count: got %0d words want 3", gotQ.size()); end
        for (int i = 0; i < 3 && i < gotQ.size() && i < expQ.size(); i++) begin
            compared++; if (gotQ[i].mask !== 32'hFFFF_FFFF) begin mismatched++; $display("[TB] FAIL burst32_mask[%0d]: got %h want ffffffff", i, gotQ[i].mask); end
            compared++; if (gotQ[i].last !== (i == 2)) begin mismatched++; $display("[TB] FAIL burst32_last[%0d]: got %b want %b", i, gotQ[i].last, i == 2); end
            compared++; if (gotQ[i].data !== expQ[i].data) begin mismatched++; $display("[TB] FAIL burst32_data[%0d]: got %h want %h", i, gotQ[i].data, expQ[i].data); end
        end
    endtask

    task automatic test_short5();
        bit to;
        startScenario();
        for (int i = 0; i < 5; i++) applyStimulus(ISIZE'($urandom), 1'b0, i == 4);
        drain(to);
        compared++; if (to || gotQ.size() != 1) begin mismatched++; $display("[TB] FAIL short5_count: got %0d words want 1", gotQ.size()); end
        if (gotQ.size() == 1 && expQ.size() == 1) begin
            compared++; if (gotQ[0].mask !== 32'h0000_7FFF) begin mismatched++; $display("[TB] FAIL short5_mask: got %h want 00007fff", gotQ[0].mask); end
            compared++; if (gotQ[0].last !== 1'b1) begin mismatched++; $display("[TB] FAIL short5_last: got %b want 1", gotQ[0].last); end
            compared++; if (gotQ[0].data !== expQ[0].data) begin mismatched++; $display("[TB] FAIL short5_data: got %h want %h", gotQ[0].data, expQ[0].data); end
        end
    endtask

    task automatic test_flush();
        bit to;
        int stall;
        startScenario();
        for (int i = 0; i < 11; i++) applyStimulus(ISIZE'($urandom), 1'b0, i == 10);
        stall = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clock);
            if (bus.iready) break;
            stall++;
        end
        compared++; if (stall != 1) begin mismatched++; $display("[TB] FAIL flush_stall: iready low %0d cycles want 1", stall); end
        drain(to);
        compared++; if (to || gotQ.size() != 2) begin mismatched++; $display("[TB] FAIL flush_count: got %0d words want 2", gotQ.size()); end
        if (gotQ.size() == 2 && expQ.size() == 2) begin
            compared++; if (gotQ[0].mask !== 32'hFFFF_FFFF || gotQ[0].last !== 1'b0) begin mismatched++; $display("[TB] FAIL flush_first: mask %h last %b want ffffffff 0", gotQ[0].mask, gotQ[0].last); end
            compared++; if (gotQ[1].mask !== 32'h0000_0001 || gotQ[1].last !== 1'b1) begin mismatched++; $display("[TB] FAIL flush_tail: mask %h last %b want 00000001 1", gotQ[1].mask, gotQ[1].last); end
            compared++; if (gotQ[0].data !== expQ[0].data || gotQ[1].data !== expQ[1].data) begin mismatched++; $display("[TB] FAIL flush_data: got %h / %h", gotQ[0].data, gotQ[1].data); end
        end
    endtask

    task automatic test_backpressure();
        bit to;
        logic [OSIZE-1:0] held;
        startScenario();
        bus.oready = 1'b0;
        for (int i = 0; i < 11; i++) applyStimulus(ISIZE'($urandom), 1'b0, 1'b0);
        held = (expQ.size() > 0) ? expQ[0].data : '0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            compared++; if (bus.owr_en !== 1'b1) begin mismatched++; $display("[TB] FAIL stall_owr_en[%0d]: got %b want 1", k, bus.owr_en); end
            compared++; if (bus.iready !== 1'b0) begin mismatched++; $display("[TB] FAIL stall_iready[%0d]: got %b want 0", k, bus.iready); end
            compared++; if (bus.odata !== held) begin mismatched++; $display("[TB] FAIL stall_odata[%0d]: got %h want %h", k, bus.odata, held); end
        end
        @(posedge clock); #1;
        bus.oready = 1'b1;
        for (int i = 0; i < 11; i++) applyStimulus(ISIZE'($urandom), 1'b0, i == 10);
        drain(to);
        compared++; if (to || gotQ.size() != expQ.size()) begin mismatched++; $display("[TB] FAIL stall_count: got %0d words want %0d", gotQ.size(), expQ.size()); end
        for (int i = 0; i < gotQ.size() && i < expQ.size(); i++) begin
            compared++; if (gotQ[i] !== expQ[i]) begin mismatched++; $display("[TB] FAIL stall_word[%0d]: got %h/%h/%b want %h/%h/%b", i, gotQ[i].data, gotQ[i].mask, gotQ[i].last, expQ[i].data, expQ[i].mask, expQ[i].last); end
        end
    endtask

    task automatic test_align();
        bit to;
        logic [ISIZE-1:0] ap;
        logic [ISIZE-1:0] aq;
        startScenario();
        for (int i = 0; i < 3; i++) applyStimulus(ISIZE'($urandom), 1'b0, 1'b0);
        ap = ISIZE'($urandom);
        applyStimulus(ap, 1'b1, 1'b0);
        applyStimulus(ISIZE'($urandom), 1'b0, 1'b0);
        applyStimulus(ISIZE'($urandom), 1'b0, 1'b1);
        drain(to);
        compared++; if (gotDrops != 1) begin mismatched++; $display("[TB] FAIL align_drop: odrop high %0d cycles want 1", gotDrops); end
        compared++; if (to || gotQ.size() != 1) begin mismatched++; $display("[TB] FAIL align_count: got %0d words want 1", gotQ.size()); end
        if (gotQ.size() == 1 && expQ.size() == 1) begin
            compared++; if (gotQ[0].data[ISIZE-1:0] !== ap) begin mismatched++; $display("[TB] FAIL align_pos: got %h want %h", gotQ[0].data[ISIZE-1:0], ap); end
            compared++; if (gotQ[0] !== expQ[0]) begin mismatched++; $display("[TB] FAIL align_word: got %h/%h want %h/%h", gotQ[0].data, gotQ[0].mask, expQ[0].data, expQ[0].mask); end
        end
        // ialign and ilast on one beat: that pixel forms the whole last word.
        for (int i = 0; i < 2; i++) applyStimulus(ISIZE'($urandom), 1'b0, 1'b0);
        aq = ISIZE'($urandom);
        applyStimulus(aq, 1'b1, 1'b1);
        drain(to);
        compared++; if (gotDrops != 2) begin mismatched++; $display("[TB] FAIL alignlast_drop: odrop high %0d cycles want 2", gotDrops); end
        compared++; if (to || gotQ.size() != 2) begin mismatched++; $display("[TB] FAIL alignlast_count: got %0d words want 2", gotQ.size()); end
        if (gotQ.size() == 2) begin
            compared++; if (gotQ[1].data !== OSIZE'(aq) || gotQ[1].mask !== 32'h0000_0007 || gotQ[1].last !== 1'b1) begin mismatched++; $display("[TB] FAIL alignlast_word: got %h/%h/%b want %h/00000007/1", gotQ[1].data, gotQ[1].mask, gotQ[1].last, aq); end
        end
    endtask

    task automatic test_reset_midburst();
        bit to;
        startScenario();
        bus.oready = 1'b0;
        for (int i = 0; i < 11; i++) applyStimulus(ISIZE'($urandom), 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        compared++; if (bus.owr_en !== 1'b0) begin mismatched++; $display("[TB] FAIL async_reset_owr_en: got %b want 0", bus.owr_en); end
        @(posedge clock); #1;
        rst = 1'b0;
        bus.oready = 1'b1;
        expQ.delete();
        resid.delete();
        repeat (10) @(posedge clock);
        #1;
        compared++; if (gotQ.size() != 0) begin mismatched++; $display("[TB] FAIL post_reset_idle: got %0d words want 0", gotQ.size()); end
        applyStimulus(ISIZE'($urandom), 1'b0, 1'b0);
        applyStimulus(ISIZE'($urandom), 1'b0, 1'b1);
        drain(to);
        compared++; if (to || gotQ.size() != 1) begin mismatched++; $display("[TB] FAIL post_reset_count: got %0d words want 1", gotQ.size()); end
        if (gotQ.size() == 1 && expQ.size() == 1) begin
            compared++; if (gotQ[0] !== expQ[0] || gotQ[0].mask !== 32'h0000_003F) begin mismatched++; $display("[TB] FAIL post_reset_word: got %h/%h want %h/0000003f", gotQ[0].data, gotQ[0].mask, expQ[0].data); end
        end
    endtask

    task automatic test_random();
        bit to;
        bit al;
        bit la;
        startScenario();
        randReady = 1;
        for (int i = 0; i < 300; i++) begin
            al = ($urandom_range(0, 15) == 0);
            la = ($urandom_range(0, 9) == 0) || (i == 299);
            applyStimulus(ISIZE'($urandom), al, la);
            if ($urandom_range(0, 4) == 0) begin
                @(posedge clock); #1;
            end
        end
        drain(to);
        compared++; if (to || gotQ.size() != expQ.size()) begin mismatched++; $display("[TB] FAIL random_count: got %0d words want %0d", gotQ.size(), expQ.size()); end
        compared++; if (gotDrops != expDrops) begin mismatched++; $display("[TB] FAIL random_drops: got %0d want %0d", gotDrops, expDrops); end
        for (int i = 0; i < gotQ.size() && i < expQ.size(); i++) begin
            compared++; if (gotQ[i] !== expQ[i]) begin mismatched++; $display("[TB] FAIL random_word[%0d]: got %h/%h/%b want %h/%h/%b", i, gotQ[i].data, gotQ[i].mask, gotQ[i].last, expQ[i].data, expQ[i].mask, expQ[i].last); end
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_burst32();
        test_short5();
        test_flush();
        test_backpressure();
        test_align();
        test_reset_midburst();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/pack_stream.md
PACK_STREAM -- requirements
Module: pack_stream

Interface
REQ-001 The block SHALL have parameter ISIZE, default 24, giving the input pixel width in bits; it SHALL be a multiple of 8 and no greater than OSIZE.
REQ-002 The block SHALL have parameter OSIZE, default 256, giving the output word width in bits; it SHALL be a multiple of 8 and need not be a multiple of ISIZE.
REQ-003 clock  in  1  sole clock; all state SHALL be updated on its rising edge.
REQ-004 rst  in  1  reset; asynchronous, active-high.
REQ-005 iwr_en  in  1  input beat valid.
REQ-006 iready  out  1  input beat accepted when iwr_en&iready.
REQ-007 idata  in  ISIZE  input pixel.
REQ-008 ialign  in  1  start-of-line marker; discards any partial word.
REQ-009 ilast  in  1  final pixel of a burst; qualified by an accepted beat.
REQ-010 owr_en  out  1  output word valid.
REQ-011 oready  in  1  downstream accepts the word when owr_en&oready.
REQ-012 odata  out  OSIZE  packed word.
REQ-013 omask  out  OSIZE/8  byte-enable for odata; bit n covers odata[8n+7:8n].
REQ-014 olast_en  out  1  marks the final word of a burst; valid with owr_en.
REQ-015 odrop  out  1  one-cycle pulse when ialign discards a non-empty partial word.

Function
REQ-016 Packing SHALL be little-endian: the first pixel accepted occupies the least significant bits, and each following pixel is placed immediately above the last valid bit, including across word boundaries.
REQ-017 An accumulator of OSIZE+ISIZE bits and a fill count SHALL track residual bits; the fill count SHALL be $clog2(OSIZE+ISIZE+1) bits wide.
REQ-018 iready SHALL equal (~owr_en | oready) & (state==RUN).
REQ-019 On an accepted beat with fill+ISIZE >= OSIZE, the low OSIZE bits SHALL be registered to odata on the next edge with omask all ones, owr_en=1, the accumulator shifted down by OSIZE, and fill reduced by OSIZE.
REQ-020 Input-to-output latency SHALL be 1 cycle.
REQ-021 While owr_en=1 and oready=0, odata, omask and olast_en SHALL hold stable.
REQ-022 On an accepted beat with ilast=1 and fill+ISIZE <= OSIZE, the block SHALL emit one word with omask low (fill+ISIZE)/8 bits set, olast_en=1, and fill cleared to 0.
REQ-023 On an accepted beat with ilast=1 and fill+ISIZE > OSIZE, the block SHALL emit a full word with olast_en=0 and enter FLUSH.
REQ-024 In FLUSH, when the output slot frees, the block SHALL emit the residual with omask low (fill/8) bits set and olast_en=1, then return to RUN with fill=0.
REQ-025 The state machine SHALL have exactly two states, RUN and FLUSH, with transitions only as given in REQ-023 and REQ-024.
REQ-026 In RUN, ialign=1 SHALL clear fill to 0 before any beat in the same cycle is placed, so that an accepted beat lands at bit 0.
REQ-027 When ialign clears a non-zero fill, the block SHALL pulse odrop and SHALL NOT emit a word.
REQ-028 If ialign and ilast arrive on the same accepted beat, that beat SHALL be packed alone and emitted as the last word.
REQ-029 Unused bits above the valid bytes in a partial word SHALL be 0.

Reset
REQ-030 Reset SHALL drive owr_en=0, olast_en=0, odrop=0, odata=0 and omask=0, clear fill and the accumulator to 0, and set the state to RUN.
REQ-031 A reset asserted mid-burst SHALL discard all residual data, and no word SHALL be emitted after release until new input arrives.

Structure
REQ-032 A shared package pack_stream_pkg SHALL hold the state enum (RUN, FLUSH) and a byte-count-to-mask function.
REQ-033 One sub-module, byte_mask_gen, SHALL convert a byte count to omask.
REQ-034 The accumulator and the state machine SHALL remain in the top module.

Verification
REQ-035 With ISIZE=24 and OSIZE=256, 11 pixels without ilast and oready=1 SHALL produce one word 1 cycle after the 11th pixel, with omask=0xFFFFFFFF and an 8-bit residual remaining.
REQ-036 32 pixels with ilast on the 32nd SHALL produce exactly 3 words, each with omask all ones, and olast_en=1 on the 3rd only.
REQ-037 5 pixels with ilast on the 5th SHALL produce one word with omask=0x00007FFF and olast_en=1.
REQ-038 11 pixels with ilast on the 11th SHALL produce a full word with olast_en=0, then a FLUSH word with omask=0x00000001 and olast_en=1, with iready=0 for 1 cycle.
REQ-039 Holding oready=0 for 4 cycles while a word is pending SHALL keep iready=0 and odata stable, and no pixel SHALL be lost.
REQ-040 Asserting ialign after 3 pixels SHALL pulse odrop once, emit no word, and place the next pixel at odata[23:0].
